// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receiver (start/data/optional parity/stop) feeding a
//            first-word-fall-through receive FIFO with per-entry parity and
//            framing flags and a sticky overrun indication.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_BITS-1:0]     rd_data,
  output logic                     rd_perr,
  output logic                     rd_ferr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t                state, state_next;
  logic                  rx_meta, rxs;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_BITS-1:0]  data_sr;
  logic                  perr_r;

  logic                  baud_tick;
  logic                  baud_clr;
  logic                  bit_clr;
  logic                  shift_en;
  logic                  par_en;
  logic                  push;

  logic [DATA_BITS-1:0]  mem_data [DEPTH];
  logic                  mem_perr [DEPTH];
  logic                  mem_ferr [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;

  assign baud_tick = (baud_cnt == BAUD_LAST);

  // Two-flop synchronizer for the asynchronous line; idles high out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode and per-cycle datapath controls for the receiver.
  always_comb begin
    state_next = state;
    baud_clr   = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    push       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_next = S_START;
          baud_clr   = 1'b1;
          bit_clr    = 1'b1;
        end
      end
      S_START: begin
        // Half a bit into the start bit: a high line means a glitch.
        if (baud_cnt == HALF_LAST) begin
          baud_clr   = 1'b1;
          state_next = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          baud_clr = 1'b1;
          shift_en = 1'b1;
          if (bit_cnt == BIT_LAST) state_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (baud_tick) begin
          baud_clr   = 1'b1;
          par_en     = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) begin
          baud_clr   = 1'b1;
          push       = 1'b1;
          state_next = rxs ? S_IDLE : S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        // A break produces one entry; wait for the line to return high.
        if (rxs) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Baud/bit counters, LSB-first shift register and parity check.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      data_sr  <= '0;
      perr_r   <= 1'b0;
    end else begin
      if (baud_clr)
        baud_cnt <= '0;
      else if (state != S_IDLE && state != S_WAIT_IDLE)
        baud_cnt <= baud_cnt + CW'(1);

      if (bit_clr) begin
        bit_cnt <= '0;
        perr_r  <= 1'b0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BW'(1);
      end

      if (shift_en) data_sr <= {rxs, data_sr[DATA_BITS-1:1]};

      // Odd parity expects the XOR over data and parity bit to be 1.
      if (par_en) perr_r <= (^data_sr) ^ rxs ^ (PARITY == 1);
    end
  end

  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign do_pop   = rd_valid & rd_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign do_push  = push & (~full | do_pop);

  // FIFO storage; contents need no reset because outputs are gated by rd_valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_data[wr_ptr] <= data_sr;
      mem_perr[wr_ptr] <= perr_r;
      mem_ferr[wr_ptr] <= ~rxs;
    end
  end

  // FIFO pointers, occupancy and sticky overrun (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      if (push && full && !do_pop)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  assign rd_data = rd_valid ? mem_data[rd_ptr] : '0;
  assign rd_perr = rd_valid ? mem_perr[rd_ptr] : 1'b0;
  assign rd_ferr = rd_valid ? mem_ferr[rd_ptr] : 1'b0;

endmodule
`default_nettype wire
